// File: rtl/tree_add_ctrl.sv
// Sequencer for the T-lane combinational tree adder.
// Mode 0 chains every beat through the adder's element input to reduce the
// job to one scalar. Mode 1 issues lane-wise a+b and returns each result
// array through a one-entry output register.
module tree_add_ctrl #(
  parameter int T     = 16,
  parameter int WIDTH = 16,
  parameter int LEN_W = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic [2:0]           i_sec_lev,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [T*WIDTH-1:0]   i_data_a,
  input  logic [T*WIDTH-1:0]   i_data_b,
  output logic                 o_ta_mode,
  output logic [2:0]           o_ta_sec_lev,
  output logic [T*WIDTH-1:0]   o_ta_a,
  output logic [T*WIDTH-1:0]   o_ta_b,
  output logic [T*WIDTH-1:0]   o_ta_array,
  output logic [WIDTH-1:0]     o_ta_element,
  input  logic [T*WIDTH-1:0]   i_ta_array,
  input  logic [WIDTH-1:0]     i_ta_element,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [T*WIDTH-1:0]   o_array,
  output logic [WIDTH-1:0]     o_element,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic                 mode_q;
  logic [2:0]           sec_q;
  logic [LEN_W-1:0]     cnt;
  logic [WIDTH-1:0]     acc;

  logic                 run, msb_clr, accept, pop;
  logic [WIDTH-1:0]     elem_m;

  logic [T-1:0][WIDTH-1:0] da, db, ta_a, ta_b, ta_sum, sum_m;

  assign da     = i_data_a;
  assign db     = i_data_b;
  assign ta_sum = i_ta_array;

  assign run     = (state == S_RUN);
  assign msb_clr = (sec_q == 3'd1);

  // In mode 0 o_valid is never set during RUN, so this is simply RUN there.
  assign o_ready = run & (!o_valid | i_out_ready);
  assign accept  = i_valid & o_ready;
  assign pop     = o_valid & i_out_ready;

  assign elem_m  = msb_clr ? {1'b0, i_ta_element[WIDTH-2:0]} : i_ta_element;

  // Per-lane operand gating and result masking
  for (genvar g = 0; g < T; g++) begin : g_lane
    tree_add_ctrl_lane #(.WIDTH(WIDTH)) u_lane (
      .run     (run),
      .msb_clr (msb_clr),
      .data_a  (da[g]),
      .data_b  (db[g]),
      .ta_sum  (ta_sum[g]),
      .ta_a    (ta_a[g]),
      .ta_b    (ta_b[g]),
      .sum_m   (sum_m[g])
    );
  end

  // Adder operands only carry data while beats are streaming
  assign o_ta_a       = ta_a;
  assign o_ta_b       = ta_b;
  assign o_ta_array   = ta_a;
  assign o_ta_element = acc;
  assign o_ta_mode    = mode_q;
  assign o_ta_sec_lev = sec_q;
  assign o_busy       = (state != S_IDLE);

  // Job FSM: latch job, stream beats, drain the result, pulse done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      sec_q     <= '0;
      cnt       <= '0;
      acc       <= '0;
      o_valid   <= 1'b0;
      o_array   <= '0;
      o_element <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            mode_q    <= i_mode;
            sec_q     <= i_sec_lev;
            cnt       <= i_len;
            acc       <= '0;
            o_valid   <= 1'b0;
            o_array   <= '0;
            o_element <= '0;
            if (i_len == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (mode_q) begin
            // Reload on accept even when popping in the same cycle
            if (accept) begin
              o_array <= sum_m;
              o_valid <= 1'b1;
            end else if (pop) begin
              o_valid <= 1'b0;
            end
          end else if (accept) begin
            acc <= elem_m;
          end
          if (accept) begin
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state <= S_DRAIN;
              if (!mode_q) begin
                o_element <= elem_m;
                o_valid   <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (pop) begin
            o_valid <= 1'b0;
            o_done  <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          acc    <= '0;
          mode_q <= 1'b0;
          sec_q  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// One adder lane: gate operands outside RUN, clear the MSB at sec_lev 1.
module tree_add_ctrl_lane #(
  parameter int WIDTH = 16
) (
  input  logic             run,
  input  logic             msb_clr,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] ta_sum,
  output logic [WIDTH-1:0] ta_a,
  output logic [WIDTH-1:0] ta_b,
  output logic [WIDTH-1:0] sum_m
);
  assign ta_a  = run ? data_a : '0;
  assign ta_b  = run ? data_b : '0;
  assign sum_m = msb_clr ? {1'b0, ta_sum[WIDTH-2:0]} : ta_sum;
endmodule
